// File: rtl/multicycle_sequencer.sv
// Multi-cycle KGP-RISC control sequencer: per-phase PC/IR/RF/memory strobes; PERF_CNT_EN adds retire/cycle counters.
// Latency: 4 cycles per ALU/BRANCH-free instruction with immediate acks, plus one cycle per memory wait state.
// Backpressure: imem_req/dmem_rd/dmem_wr held until ready; TIMEOUT_CYCLES unacked cycles trap to ERROR.
module multicycle_sequencer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       step_mode,
    input  logic [5:0] opcode,
    input  logic       branch_taken,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       dmem_rd,
    output logic       dmem_wr,
    output logic       ir_we,
    output logic       rf_we,
    output logic       pc_we,
    output logic       pc_sel,
    output logic       wb_sel,
    output logic       retire,
    output logic [2:0] state,
    output logic       halted,
    output logic       error
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] cycle_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    if (TIMEOUT_CYCLES < 1 || CNT_W < 1) begin : g_param_check
        $error("multicycle_sequencer: TIMEOUT_CYCLES and CNT_W must be >= 1");
    end

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic is_alu, is_load, is_store, is_branch, is_halt;
    logic imem_req_c, dmem_rd_c, dmem_wr_c, ir_we_c, rf_we_c;
    logic pc_we_c, pc_sel_c, wb_sel_c, retire_c;

    assign is_alu    = (opcode == 6'b000000) || (opcode == 6'b000001);
    assign is_load   = (opcode == 6'b000010);
    assign is_store  = (opcode == 6'b000011);
    assign is_branch = (opcode == 6'b000100);
    assign is_halt   = (opcode == 6'b111111);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        imem_req_c = 1'b0;
        dmem_rd_c  = 1'b0;
        dmem_wr_c  = 1'b0;
        ir_we_c    = 1'b0;
        rf_we_c    = 1'b0;
        pc_we_c    = 1'b0;
        pc_sel_c   = 1'b0;
        wb_sel_c   = 1'b0;
        retire_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ready) begin
                    ir_we_c = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                if (is_halt)                                        state_d = S_HALT;
                else if (is_alu || is_load || is_store || is_branch) state_d = S_EXEC;
                else                                                state_d = S_ERROR;
            end
            S_EXEC: begin
                if (is_alu) begin
                    state_d = S_WB;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else if (is_branch) begin
                    pc_we_c  = 1'b1;
                    pc_sel_c = branch_taken;
                    retire_c = 1'b1;
                    state_d  = step_mode ? S_IDLE : S_FETCH;
                end else begin
                    state_d = S_ERROR;
                end
            end
            S_MEM: begin
                dmem_rd_c = is_load;
                dmem_wr_c = is_store;
                if (!(is_load || is_store)) begin
                    state_d = S_ERROR;
                end else if (dmem_ready) begin
                    if (is_load) begin
                        state_d = S_WB;
                    end else begin
                        pc_we_c  = 1'b1;
                        retire_c = 1'b1;
                        state_d  = step_mode ? S_IDLE : S_FETCH;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                rf_we_c  = 1'b1;
                pc_we_c  = 1'b1;
                retire_c = 1'b1;
                wb_sel_c = is_load;
                state_d  = step_mode ? S_IDLE : S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase
        // Every phase change starts a fresh wait window for the next request.
        if (state_d != state_q) wait_d = '0;
    end

    // Reset forces every output low combinationally so a pending request drops in the reset cycle.
    assign imem_req = imem_req_c & ~rst;
    assign dmem_rd  = dmem_rd_c  & ~rst;
    assign dmem_wr  = dmem_wr_c  & ~rst;
    assign ir_we    = ir_we_c    & ~rst;
    assign rf_we    = rf_we_c    & ~rst;
    assign pc_we    = pc_we_c    & ~rst;
    assign pc_sel   = pc_sel_c   & ~rst;
    assign wb_sel   = wb_sel_c   & ~rst;
    assign retire   = retire_c   & ~rst;
    assign state    = rst ? 3'd0 : state_q;
    assign halted   = ~rst & (state_q == S_HALT);
    assign error    = ~rst & (state_q == S_ERROR);

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] instr_q, cycle_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= '0;
            cycle_q <= '0;
        end else begin
            if (retire_c) instr_q <= instr_q + CNT_W'(1);
            if (state_q inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB})
                cycle_q <= cycle_q + CNT_W'(1);
        end
    end

    assign instr_count = instr_q;
    assign cycle_count = cycle_q;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: expected per-cycle traces are built from instruction-level rules.
module tb_multicycle_sequencer;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst, start, step_mode, branch_taken, imem_ready, dmem_ready;
    logic [5:0] opcode;
    logic       imem_req, dmem_rd, dmem_wr, ir_we, rf_we, pc_we, pc_sel, wb_sel, retire;
    logic [2:0] state;
    logic       halted, error;
`ifdef PERF_CNT_EN
    logic [31:0] instr_count, cycle_count;
    logic [31:0] m_instr = '0, m_cycle = '0;
`endif

    always #5 clk = ~clk;

    multicycle_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .opcode(opcode),
        .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .ir_we(ir_we),
        .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel), .wb_sel(wb_sel), .retire(retire),
        .state(state), .halted(halted), .error(error)
`ifdef PERF_CNT_EN
        , .instr_count(instr_count), .cycle_count(cycle_count)
`endif
    );

    typedef struct packed {
        logic       rst, start, step_mode, branch_taken, imem_ready, dmem_ready;
        logic [5:0] opcode;
    } drv_t;

    typedef struct packed {
        logic [2:0] state;
        logic imem_req, dmem_rd, dmem_wr, ir_we, rf_we, pc_we, pc_sel, wb_sel, retire, halted, error;
    } exp_t;

    drv_t q_drv[$];
    exp_t q_exp[$];
    int   n_vec = 0;
    int   n_bad = 0;
    bit   at_idle = 1'b1;

    function automatic exp_t mk(input logic [2:0] st);
        exp_t x = '0;
        x.state  = st;
        x.halted = (st == 3'd6);
        x.error  = (st == 3'd7);
        return x;
    endfunction

    // Inputs that the current phase must ignore are randomised.
    function automatic drv_t rnd(input logic [5:0] opc);
        drv_t d;
        d.rst          = 1'b0;
        d.start        = 1'($urandom);
        d.step_mode    = 1'($urandom);
        d.branch_taken = 1'($urandom);
        d.imem_ready   = 1'($urandom);
        d.dmem_ready   = 1'($urandom);
        d.opcode       = opc;
        return d;
    endfunction

    task automatic push(input drv_t d, input exp_t x);
        q_drv.push_back(d);
        q_exp.push_back(x);
    endtask

    task automatic do_reset();
        drv_t d;
        d = rnd(6'($urandom));
        d.rst = 1'b1;
        push(d, mk(3'd0));
        at_idle = 1'b1;
    endtask

    task automatic terminal(input logic [2:0] st);
        drv_t d;
        for (int i = 0; i < 3; i++) begin
            d = rnd(6'($urandom));
            d.start = 1'b1;
            push(d, mk(st));
        end
        do_reset();
    endtask

    // One instruction: iw/dw are wait cycles before ready (>= TO means ready never comes).
    task automatic gen_instr(input logic [5:0] opc, input int iw, input int dw,
                             input bit bt, input bit sm, input bit rst_in_mem);
        drv_t d;
        exp_t x;
        bit   ld, st;
        ld = (opc == 6'd2);
        st = (opc == 6'd3);
        if (at_idle) begin
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
                d = rnd(6'($urandom));
                d.start = 1'b0;
                push(d, mk(3'd0));
            end
            d = rnd(6'($urandom));
            d.start = 1'b1;
            push(d, mk(3'd0));
        end
        for (int k = 0; k < TO; k++) begin
            d = rnd(6'($urandom));
            d.imem_ready = (k == iw);
            x = mk(3'd1);
            x.imem_req = 1'b1;
            x.ir_we    = (k == iw);
            push(d, x);
            if (k == iw) break;
        end
        if (iw >= TO) begin terminal(3'd7); return; end
        push(rnd(opc), mk(3'd2));
        if (opc == 6'h3f) begin terminal(3'd6); return; end
        if (opc > 6'd4) begin terminal(3'd7); return; end
        d = rnd(opc);
        x = mk(3'd3);
        if (opc == 6'd4) begin
            d.branch_taken = bt;
            d.step_mode    = sm;
            x.pc_we  = 1'b1;
            x.pc_sel = bt;
            x.retire = 1'b1;
            push(d, x);
            at_idle = sm;
            return;
        end
        push(d, x);
        if (ld || st) begin
            for (int k = 0; k < TO; k++) begin
                d = rnd(opc);
                d.dmem_ready = (k == dw);
                if (rst_in_mem && k == 1) begin
                    d.rst = 1'b1;
                    push(d, mk(3'd0));
                    at_idle = 1'b1;
                    return;
                end
                x = mk(3'd4);
                x.dmem_rd = ld;
                x.dmem_wr = st;
                if (k == dw && st) begin
                    d.step_mode = sm;
                    x.pc_we  = 1'b1;
                    x.retire = 1'b1;
                end
                push(d, x);
                if (k == dw) break;
            end
            if (dw >= TO) begin terminal(3'd7); return; end
            if (st) begin at_idle = sm; return; end
        end
        d = rnd(opc);
        d.step_mode = sm;
        x = mk(3'd5);
        x.rf_we  = 1'b1;
        x.pc_we  = 1'b1;
        x.retire = 1'b1;
        x.wb_sel = ld;
        push(d, x);
        at_idle = sm;
    endtask

    task automatic run_q();
        drv_t d;
        exp_t x, got;
        while (q_drv.size() > 0) begin
            d = q_drv.pop_front();
            x = q_exp.pop_front();
            @(negedge clk);
            rst = d.rst; start = d.start; step_mode = d.step_mode;
            branch_taken = d.branch_taken; imem_ready = d.imem_ready;
            dmem_ready = d.dmem_ready; opcode = d.opcode;
            #1;
            got = {state, imem_req, dmem_rd, dmem_wr, ir_we, rf_we, pc_we, pc_sel,
                   wb_sel, retire, halted, error};
            n_vec++;
            assert (got === x) else begin
                n_bad++;
                $error("FAIL outputs step %0d: got %b expected %b", n_vec, got, x);
            end
`ifdef PERF_CNT_EN
            if (!d.rst) begin
                n_vec++;
                assert ({instr_count, cycle_count} === {m_instr, m_cycle}) else begin
                    n_bad++;
                    $error("FAIL counters step %0d: got %0d/%0d expected %0d/%0d",
                           n_vec, instr_count, cycle_count, m_instr, m_cycle);
                end
            end
            if (d.rst) begin
                m_instr = '0;
                m_cycle = '0;
            end else begin
                if (x.retire) m_instr++;
                if (x.state >= 3'd1 && x.state <= 3'd5) m_cycle++;
            end
`endif
        end
    endtask

    function automatic logic [5:0] rand_opc();
        int r = int'($urandom_range(0, 99));
        if (r < 90) return 6'($urandom_range(0, 4));
        if (r < 95) return 6'h3f;
        return 6'($urandom_range(5, 62));
    endfunction

    function automatic int rand_wait();
        int r = int'($urandom_range(0, 99));
        if (r < 85) return int'($urandom_range(0, 3));
        if (r < 93) return TO - 1;
        return TO;
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; step_mode = 1'b0; branch_taken = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0; opcode = '0;
        do_reset();
        do_reset();
        run_q();
        gen_instr(6'd0, 0, 0, 1'b0, 1'b0, 1'b0); run_q();   // ALU-reg, immediate ack
        gen_instr(6'd2, 0, 3, 1'b0, 1'b0, 1'b0); run_q();   // LOAD, 3 data waits
        gen_instr(6'd4, 0, 0, 1'b1, 1'b0, 1'b0); run_q();   // taken branch
        gen_instr(6'd1, TO - 1, 0, 1'b0, 1'b0, 1'b0); run_q(); // ready on the timeout cycle
        gen_instr(6'd3, 1, 2, 1'b0, 1'b1, 1'b0); run_q();   // STORE with step_mode
        gen_instr(6'd2, 0, 4, 1'b0, 1'b0, 1'b1); run_q();   // reset mid-MEM
        gen_instr(6'd3, 0, 0, 1'b0, 1'b1, 1'b0); run_q();   // STORE from reset, step_mode
        gen_instr(6'd0, TO, 0, 1'b0, 1'b0, 1'b0); run_q();  // fetch timeout
        gen_instr(6'd3, 0, TO, 1'b0, 1'b0, 1'b0); run_q();  // data timeout
        gen_instr(6'h3f, 0, 0, 1'b0, 1'b0, 1'b0); run_q();  // HALT
        gen_instr(6'h2a, 0, 0, 1'b0, 1'b0, 1'b0); run_q();  // illegal opcode
        for (int i = 0; i < 200; i++) begin
            gen_instr(rand_opc(), rand_wait(), rand_wait(), 1'($urandom), 1'($urandom),
                      ($urandom_range(0, 29) == 0));
            run_q();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
